mdiv_unit: RTL and testbench
============================

Name: mdiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS-style core.
- Launched from the M1 stage by MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Produces MDIV_BUSY, which the hazard unit combines with an mfhi/mflo select in M to stall F/D/E/M; HI/LO feed the mfhi/mflo result mux.
- Radix-2, one bit per cycle, shared datapath for multiply and divide.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- CLK  in  1  core clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle launch strobe; asserted only in a cycle where the M1 stage is not stalled
- OP  in  3  mdiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- SRC_A  in  WIDTH  rs operand (multiplicand / dividend / MTHI–MTLO data)
- SRC_B  in  WIDTH  rt operand (multiplier / divisor)
- BUSY  out  1  high while an operation is in flight; drives MDIV_BUSY_M
- HI  out  WIDTH  architectural HI
- LO  out  WIDTH  architectural LO

Behaviour:
- Reset: state IDLE; HI=0, LO=0, BUSY=0; counter and working registers cleared. RESET mid-operation aborts the operation; the next cycle is IDLE with HI/LO=0.
- Clocking: synchronous to CLK only. BUSY is registered and equals (state != IDLE).
- States: IDLE, CALC, FIXUP.
- IDLE + START with OP=MTHI/MTLO:
  - HI (or LO) <= SRC_A at the next edge.
  - Stays IDLE; BUSY stays 0.
- IDLE + START with MULT/MULTU/DIV/DIVU:
  - Latch |SRC_A| and |SRC_B|. Signed ops negate negative operands; unsigned ops take them as-is.
  - Latch the result sign flags: product/quotient sign = sa^sb; remainder sign = sa.
  - Load counter = WIDTH; go to CALC.
- CALC, one iteration per cycle, counter decrements; leave for FIXUP when counter reaches 1→0.
  - Multiply: shift-add into a 2*WIDTH accumulator {acc_hi, acc_lo}.
  - Divide: restoring divide. Shift the remainder left, subtract the divisor with a (WIDTH+1)-bit subtractor, keep the difference if non-negative, and shift the quotient bit in.
- FIXUP, one cycle:
  - Apply two's-complement negation per the sign flags.
  - Write results: multiply gives HI=product[2W-1:W], LO=product[W-1:0]; divide gives LO=quotient, HI=remainder.
  - Next state IDLE.
- Latency: START in cycle N → BUSY=1 in cycles N+1..N+WIDTH+1 → HI/LO valid and BUSY=0 in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- HI/LO hold their old values throughout CALC/FIXUP and change only at the FIXUP→IDLE edge.
- START while BUSY:
  - The in-flight operation is abandoned without writing HI/LO.
  - A new MULT/DIV restarts CALC with the new operands.
  - MTHI/MTLO writes its register and returns to IDLE.
- Divide by zero:
  - No trap, deterministic result: LO = all ones; HI = dividend.
  - Signed divide applies sign fixup to this result: quotient sign = sa^0, remainder sign = sa.
- Signed overflow (-2^31 / -1): LO=0x80000000, HI=0. The unsigned magnitude path yields this naturally.
- START is sampled only in IDLE/CALC/FIXUP as above. OP values outside the enum are ignored (no state change).

Decomposition:
- Shared package core_pkg:
  - mdiv_op_t enum (3 bits), mdiv_state_t enum.
  - Helper constant for the WIDTH default.
- Sub-module mdiv_negate (conditional two's-complement, parameterised width). Used at operand capture and at FIXUP; instantiated for 32-bit operands and 64-bit product.
- The FSM and datapath stay in mdiv_unit.

Test Plan:
- Unsigned multiply: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → BUSY high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply: MULT A=-7 (0xFFFFFFF9), B=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6.
- Signed divide: DIV A=-17, B=5 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2). DIVU A=100, B=7 → LO=14, HI=2.
- Divide corners:
  - DIVU A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x1234.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Restart and move-to:
  - MULT started, MTLO 0xCAFE issued 10 cycles later → BUSY drops next cycle; LO=0xCAFE; HI unchanged from before the MULT.
  - MTHI 0xBEEF from IDLE → HI=0xBEEF one cycle later; BUSY never asserts.
- Reset mid-CALC: assert RESET at iteration 16 of a DIV → next cycle BUSY=0, HI=LO=0; a fresh MULTU 3×4 afterwards gives LO=12, HI=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MDIV_WIDTH   : default operand and HI/LO width
//   mdiv_op_t    : operation code presented on OP when START is asserted
//   mdiv_state_t : sequencer states of mdiv_unit
package core_pkg;

  localparam int MDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } mdiv_state_t;

endpackage

// File: rtl/mdiv_negate.sv
// Conditional two's-complement negation.
//   W      : data width
//   en_i   : 1 = output is -val_i, 0 = output is val_i
//   val_i  : input value
//   val_o  : conditionally negated value
module mdiv_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mdiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO
// registers. One result bit per cycle on a shared (WIDTH+1)-bit adder.
//   CLK    : core clock
//   RESET  : synchronous active-high reset
//   START  : one-cycle launch strobe
//   OP     : mdiv_op_t operation code
//   SRC_A  : rs operand (multiplicand / dividend / move-to data)
//   SRC_B  : rt operand (multiplier / divisor)
//   BUSY   : operation in flight
//   HI, LO : architectural HI and LO
module mdiv_unit
  import core_pkg::*;
#(
  parameter int  WIDTH = MDIV_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  output logic             BUSY,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdiv_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               sign_pq_q, sign_pq_d, sign_r_q, sign_r_d;
  logic               busy_q, busy_d;

  // Operation decode
  logic op_mul, op_div, op_signed, start_mv, start_md, sa, sb;
  assign op_mul    = (OP == MD_MULT) || (OP == MD_MULTU);
  assign op_div    = (OP == MD_DIV)  || (OP == MD_DIVU);
  assign op_signed = (OP == MD_MULT) || (OP == MD_DIV);
  assign start_mv  = START && ((OP == MD_MTHI) || (OP == MD_MTLO));
  assign start_md  = START && (op_mul || op_div);
  assign sa        = op_signed & SRC_A[WIDTH-1];
  assign sb        = op_signed & SRC_B[WIDTH-1];

  // Operand magnitudes at capture
  logic [WIDTH-1:0] abs_a, abs_b;
  mdiv_negate #(.W(WIDTH)) u_neg_a (.en_i(sa), .val_i(SRC_A), .val_o(abs_a));
  mdiv_negate #(.W(WIDTH)) u_neg_b (.en_i(sb), .val_i(SRC_B), .val_o(abs_b));

  // Shared adder: multiply adds the multiplicand to acc_hi; divide subtracts
  // the divisor from the left-shifted partial remainder. The remainder stays
  // below 2*divisor, so bit WIDTH of the difference is a valid sign bit (and
  // with a zero divisor the shifted remainder never reaches bit WIDTH).
  logic [WIDTH:0] shifted, add_a, add_b, sum;
  logic           keep;
  assign shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign add_a   = is_div_q ? shifted : {1'b0, acc_hi_q};
  assign add_b   = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
  assign sum     = add_a + add_b + {{WIDTH{1'b0}}, is_div_q};
  assign keep    = ~sum[WIDTH];

  // Result sign fixup: quotient reuses the low half of the product negator
  logic [2*WIDTH-1:0] prod_in, prod_res;
  logic [WIDTH-1:0]   rem_res;
  assign prod_in = is_div_q ? {{WIDTH{1'b0}}, acc_lo_q} : {acc_hi_q, acc_lo_q};
  mdiv_negate #(.W(2*WIDTH)) u_neg_p (.en_i(sign_pq_q), .val_i(prod_in), .val_o(prod_res));
  mdiv_negate #(.W(WIDTH))   u_neg_r (.en_i(sign_r_q), .val_i(acc_hi_q), .val_o(rem_res));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    sign_pq_d = sign_pq_q;
    sign_r_d  = sign_r_q;
    // A new START (in any state) abandons whatever is in flight.
    if (start_mv) begin
      if (OP == MD_MTHI) hi_d = SRC_A;
      else               lo_d = SRC_A;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (start_md) begin
      opnd_d    = op_div ? abs_b : abs_a;
      acc_hi_d  = '0;
      acc_lo_d  = op_div ? abs_a : abs_b;
      is_div_d  = op_div;
      sign_pq_d = sa ^ sb;
      sign_r_d  = sa;
      cnt_d     = CNT_W'(WIDTH);
      state_d   = ST_CALC;
    end else begin
      case (state_q)
        ST_CALC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_hi_d = keep ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], keep};
          end else if (acc_lo_q[0]) begin
            acc_hi_d = sum[WIDTH:1];
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
          end else begin
            acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
            acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
        end
        ST_FIXUP: begin
          lo_d    = prod_res[WIDTH-1:0];
          hi_d    = is_div_q ? rem_res : prod_res[2*WIDTH-1:WIDTH];
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      sign_pq_q <= 1'b0;
      sign_r_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      sign_pq_q <= sign_pq_d;
      sign_r_q  <= sign_r_d;
      busy_q    <= busy_d;
    end
  end

  assign BUSY = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdiv_unit.sv
// Self-checking bench for mdiv_unit: directed cases with literal results plus
// randomized operation streams against a behavioural result/latency model.
module tb_mdiv_unit;
  import core_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET, START;
  logic [2:0]   OP;
  logic [W-1:0] SRC_A, SRC_B;
  logic         BUSY;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  mdiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .BUSY(BUSY), .HI(HI), .LO(LO)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural result of an operation as {HI, LO}
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (op)
      MD_MULTU: p = 64'(a) * 64'(b);
      MD_MULT:  p = sa * sb;
      MD_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_DIV: begin
        if (b == 0) p = {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Behavioural model: result appears WIDTH+2 cycles after the launch cycle
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int m_rem = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (START && (OP inside {MD_MTHI, MD_MTLO})) begin
      if (OP == MD_MTHI) m_hi = SRC_A;
      else               m_lo = SRC_A;
      m_rem = 0;
    end else if (START && (OP inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})) begin
      {p_hi, p_lo} = ref_result(OP, SRC_A, SRC_B);
      m_rem = W + 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, BUSY}, {31'b0, (m_rem != 0)});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nbusy);
    @(negedge CLK);
    START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
    @(negedge CLK);
    START = 1'b0;
    nbusy = 0;
    while (BUSY && nbusy < 200) begin
      nbusy++;
      @(negedge CLK);
    end
    if (nbusy >= 200) begin
      checks++; failures++;
      $display("FAIL timeout actual=busy required=idle");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    RESET = 1'b1; START = 1'b0; OP = '0; SRC_A = '0; SRC_B = '0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_busy", {31'b0, BUSY}, 32'h0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    RESET = 1'b0;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    check("multu_busy_cycles", 32'(nb), 32'd33);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);
    check("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    run_op(MD_MULT, 32'hFFFF_FFF9, 32'd6, nb);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFD6);
    check("model_mult_lo", m_lo, 32'hFFFF_FFD6);

    run_op(MD_DIV, 32'hFFFF_FFEF, 32'd5, nb);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFE);
    check("model_div_hi", m_hi, 32'hFFFF_FFFE);

    run_op(MD_DIVU, 32'd100, 32'd7, nb);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    run_op(MD_DIVU, 32'h1234, 32'h0, nb);
    check("divu0_lo", LO, 32'hFFFF_FFFF);
    check("divu0_hi", HI, 32'h1234);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0);
    check("model_divovf_lo", m_lo, 32'h8000_0000);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0, nb);
    check("div0neg_lo", LO, 32'h0000_0001);
    check("div0neg_hi", HI, 32'hFFFF_FFF9);

    run_op(MD_MTHI, 32'hBEEF, 32'h0, nb);
    check("mthi_busy_cycles", 32'(nb), 32'd0);
    check("mthi_hi", HI, 32'hBEEF);

    // MTLO 10 cycles into a MULT abandons it
    @(negedge CLK);
    START = 1'b1; OP = MD_MULT; SRC_A = 32'd123; SRC_B = 32'd456;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    START = 1'b1; OP = MD_MTLO; SRC_A = 32'hCAFE;
    @(negedge CLK);
    START = 1'b0;
    check("restart_busy", {31'b0, BUSY}, 32'h0);
    check("restart_lo", LO, 32'hCAFE);
    check("restart_hi", HI, 32'hBEEF);
    repeat (40) @(negedge CLK);
    check("restart_lo_held", LO, 32'hCAFE);

    // Reset at iteration 16 of a divide
    @(negedge CLK);
    START = 1'b1; OP = MD_DIV; SRC_A = 32'hFFFF_FF9C; SRC_B = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (15) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst_busy", {31'b0, BUSY}, 32'h0);
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    run_op(MD_MULTU, 32'd3, 32'd4, nb);
    check("postrst_lo", LO, 32'd12);
    check("postrst_hi", HI, 32'd0);

    // Random stream, including overlapping starts and undefined opcodes
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      START = 1'b1;
      OP = 3'($urandom_range(0, 7));
      SRC_A = pick();
      SRC_B = pick();
      @(negedge CLK);
      START = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge CLK);
    end
    nb = 0;
    while (BUSY && nb < 200) begin
      nb++;
      @(negedge CLK);
    end
    if (nb >= 200) begin
      checks++; failures++;
      $display("FAIL final_timeout actual=busy required=idle");
    end
    repeat (2) @(negedge CLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
